instruction_memory_responder: RTL and testbench

- Responder end of the fetch-unit/IMEM interface. Serves two simultaneous instruction reads: the branch-not-taken word at IP and the branch-taken word at IP2. Each read has a fixed 1-cycle latency.
- Also owns the host-side code-load path. The host streams 64-bit instructions as 32-bit halves into a contiguous address range, under a valid/ready handshake and a load state machine.
- Sits in the MEM unit between the host interface and the instruction fetch unit.

---
 rtl/instruction_memory_responder_if.sv | 33 +++
 rtl/instruction_memory_responder.sv | 168 ++++++++++++++++
 tb/tb_instruction_memory_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_responder_if.sv
// Fetch-unit / host bus seen by the instruction memory responder.
// master: fetch unit plus host loader; slave: the memory responder.
interface instruction_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 64
);
  // Dual fetch read ports
  logic [ADDR_WIDTH-1:0]  ip;
  logic [ADDR_WIDTH-1:0]  ip2;
  logic [INSTR_WIDTH-1:0] instruction1;
  logic [INSTR_WIDTH-1:0] instruction2;

  // Host code-load path
  logic                   load_start;
  logic [ADDR_WIDTH-1:0]  load_base_address;
  logic [ADDR_WIDTH-1:0]  load_count;
  logic [31:0]            load_data;
  logic                   load_valid;
  logic                   load_ready;
  logic                   busy;
  logic                   load_done;
  logic                   load_error;

  modport master (
    output ip, ip2, load_start, load_base_address, load_count, load_data, load_valid,
    input  instruction1, instruction2, load_ready, busy, load_done, load_error
  );

  modport slave (
    input  ip, ip2, load_start, load_base_address, load_count, load_data, load_valid,
    output instruction1, instruction2, load_ready, busy, load_done, load_error
  );
endinterface

// File: rtl/instruction_memory_responder.sv
// Instruction memory responder: two registered fetch reads (not-taken / taken
// paths) plus a host code-load engine that assembles 64-bit words from two
// 32-bit halves and commits them to a contiguous address range.
module instruction_memory_responder #(
  parameter int unsigned            ADDR_WIDTH  = 16,
  parameter int unsigned            DEPTH       = 1024,
  parameter int unsigned            INSTR_WIDTH = 64,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input logic                           clk,
  input logic                           rst_n,
  instruction_memory_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadLo,
    StLoadHi,
    StCommit,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d;
  logic [31:0]            lo_q, lo_d;
  logic [31:0]            hi_q, hi_d;
  logic                   error_q, error_d;
  logic                   done_q;
  logic [INSTR_WIDTH-1:0] instr1_q, instr1_d;
  logic [INSTR_WIDTH-1:0] instr2_q, instr2_d;

  logic                   load_ready;
  logic                   busy;
  logic                   wr_en;
  logic [INSTR_WIDTH-1:0] wr_data;

  // Storage is intentionally not reset; only the control path is.
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign wr_data = {hi_q, lo_q};

  // Load FSM next-state, datapath and handshake outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    error_d    = error_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.load_start) begin
          addr_d  = bus.load_base_address;
          count_d = bus.load_count;
          error_d = 1'b0;
          state_d = (bus.load_count == '0) ? StDone : StLoadLo;
        end
      end
      StLoadLo: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (bus.load_valid) begin
          lo_d    = bus.load_data;
          state_d = StLoadHi;
        end
      end
      StLoadHi: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (bus.load_valid) begin
          hi_d    = bus.load_data;
          state_d = StCommit;
        end
      end
      StCommit: begin
        busy = 1'b1;
        // Out-of-range writes are dropped but flagged; the address still advances.
        if (in_range(addr_q)) begin
          wr_en = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        addr_d  = addr_q + ADDR_WIDTH'(1);
        count_d = count_q - ADDR_WIDTH'(1);
        state_d = (count_q == ADDR_WIDTH'(1)) ? StDone : StLoadLo;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Load FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      error_q <= error_d;
      done_q  <= (state_q == StDone);
    end
  end

  // Memory write port, driven only by the COMMIT state
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_q[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read data selection: write-first bypass, then array, then NOP for out-of-range
  always_comb begin
    instr1_d = NOP_WORD;
    instr2_d = NOP_WORD;
    if (wr_en && (bus.ip == addr_q)) begin
      instr1_d = wr_data;
    end else if (in_range(bus.ip)) begin
      instr1_d = mem[bus.ip[IDX_W-1:0]];
    end
    if (wr_en && (bus.ip2 == addr_q)) begin
      instr2_d = wr_data;
    end else if (in_range(bus.ip2)) begin
      instr2_d = mem[bus.ip2[IDX_W-1:0]];
    end
  end

  // Registered read outputs, one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr1_q <= '0;
      instr2_q <= '0;
    end else begin
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
    end
  end

  assign bus.instruction1 = instr1_q;
  assign bus.instruction2 = instr2_q;
  assign bus.load_ready   = load_ready;
  assign bus.busy         = busy;
  assign bus.load_done    = done_q;
  assign bus.load_error   = error_q;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: directed load/read scenarios followed
// by random loads with random fetch addresses. Read responses go through a
// scoreboard queue; a sparse associative array is the reference memory.
module tb_instruction_memory_responder;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IW    = 64;
  localparam logic [IW-1:0] NOP = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rd = 1'b0;
  bit   err_m = 1'b0;
  logic [63:0] mem_m [int unsigned];

  typedef struct {
    bit          k1;
    bit          k2;
    logic [63:0] e1;
    logic [63:0] e2;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  instruction_memory_responder_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  instruction_memory_responder #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .INSTR_WIDTH(IW),
    .NOP_WORD   (NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] model_rd(input logic [15:0] a, output bit known);
    known = 1'b0;
    if (32'(a) >= DEPTH) begin
      known = 1'b1;
      return NOP;
    end
    if (mem_m.exists(32'(a))) begin
      known = 1'b1;
      return mem_m[32'(a)];
    end
    return 64'd0;
  endfunction

  function automatic logic [15:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'($urandom_range(DEPTH, 65535));
    if (r == 1) return 16'($urandom_range(DEPTH - 2, DEPTH + 1));
    return 16'($urandom_range(0, 63));
  endfunction

  // Recorder: each edge, predict what the read registers capture.
  initial begin : recorder
    rd_exp_t e;
    bit      k;
    forever begin
      @(posedge clk);
      e.e1 = model_rd(bus.ip, k);
      e.k1 = k && rst_n;
      e.e2 = model_rd(bus.ip2, k);
      e.k2 = k && rst_n;
      sb_q.push_back(e);
    end
  end

  // Monitor: compare registered outputs mid-cycle.
  initial begin : monitor
    rd_exp_t m;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        m = sb_q.pop_front();
        if (rst_n) begin
          if (m.k1) chk("rd1", bus.instruction1, m.e1);
          if (m.k2) chk("rd2", bus.instruction2, m.e2);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rd) begin
      bus.ip  = pick_addr();
      bus.ip2 = pick_addr();
    end
  endtask

  task automatic send_half(input logic [31:0] d, output bit ok);
    bus.load_data  = d;
    bus.load_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.load_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: ready low for 20 cycles, expected a handshake");
    end
  endtask

  task automatic do_load(input logic [15:0] base, input logic [15:0] cnt, input logic [63:0] w0,
                         input logic [63:0] w1, input int gap, input bit mid_start,
                         input bit wf);
    logic [15:0] a;
    logic [63:0] w;
    bit          ok;
    bus.load_base_address = base;
    bus.load_count        = cnt;
    bus.load_start        = 1'b1;
    tick();
    bus.load_start = 1'b0;
    a     = base;
    err_m = 1'b0;
    w     = w0;
    if (cnt != 0) begin
      chk("busy_in_load", 64'(bus.busy), 64'd1);
      chk("ready_lo", 64'(bus.load_ready), 64'd1);
    end
    for (int k = 0; k < int'(cnt); k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : {$urandom, $urandom};
      send_half(w[31:0], ok);
      if (!ok) return;
      if (k == 0 && gap > 0) begin
        bus.load_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          if (mid_start && g == 1) begin
            bus.load_start        = 1'b1;
            bus.load_base_address = 16'h0030;
            bus.load_count        = 16'd5;
          end
          tick();
          bus.load_start = 1'b0;
        end
        chk("hold_hi_ready", 64'(bus.load_ready), 64'd1);
      end
      send_half(w[63:32], ok);
      if (!ok) return;
      if (32'(a) < DEPTH) mem_m[32'(a)] = w;
      else err_m = 1'b1;
      a = a + 16'd1;
    end
    bus.load_valid = 1'b0;
    if (cnt != 0) begin
      chk("done_early", 64'(bus.load_done), 64'd0);
      tick();
      if (wf) chk("write_first", bus.instruction1, w);
    end
    chk("done_not_yet", 64'(bus.load_done), 64'd0);
    chk("busy_in_done", 64'(bus.busy), 64'd0);
    tick();
    chk("done_pulse", 64'(bus.load_done), 64'd1);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("load_error", 64'(bus.load_error), 64'(err_m));
    tick();
    chk("done_one_cycle", 64'(bus.load_done), 64'd0);
  endtask

  initial begin : stim
    logic [63:0] wa;
    logic [63:0] wb;
    bit          ok;
    bus.ip = '0;
    bus.ip2 = '0;
    bus.load_start = 1'b0;
    bus.load_base_address = '0;
    bus.load_count = '0;
    bus.load_data = '0;
    bus.load_valid = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_instr1", bus.instruction1, 64'd0);
    chk("rst_instr2", bus.instruction2, 64'd0);
    chk("rst_ready", 64'(bus.load_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.load_done), 64'd0);
    chk("rst_error", 64'(bus.load_error), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Basic two-word load, valid held high
    do_load(16'h0010, 16'd2, 64'h2222222211111111, 64'h4444444433333333, 0, 1'b0, 1'b0);

    // Dual read and one-cycle latency
    bus.ip  = 16'h0010;
    bus.ip2 = 16'h0011;
    tick();
    chk("read1", bus.instruction1, 64'h2222222211111111);
    chk("read2", bus.instruction2, 64'h4444444433333333);
    bus.ip = 16'h0011;
    chk("latency_hold", bus.instruction1, 64'h2222222211111111);
    tick();
    chk("latency_follow", bus.instruction1, 64'h4444444433333333);

    // Load crossing the top of memory
    do_load(16'(DEPTH - 1), 16'd2, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b0);
    bus.ip  = 16'(DEPTH);
    bus.ip2 = 16'(DEPTH - 1);
    tick();
    chk("oor_nop", bus.instruction1, NOP);
    chk("top_word", bus.instruction2, mem_m[DEPTH - 1]);

    // Valid gap between halves with a start pulse that must be ignored
    do_load(16'h0018, 16'd2, {$urandom, $urandom}, {$urandom, $urandom}, 5, 1'b1, 1'b0);
    bus.ip  = 16'h0018;
    bus.ip2 = 16'h0019;
    tick();
    chk("gap_word0", bus.instruction1, mem_m[32'h18]);
    chk("gap_word1", bus.instruction2, mem_m[32'h19]);

    // Zero-count load
    do_load(16'h0040, 16'd0, 64'd0, 64'd0, 0, 1'b0, 1'b0);

    // Write-first read while committing
    bus.ip = 16'h0012;
    tick();
    do_load(16'h0012, 16'd1, {$urandom, $urandom}, 64'd0, 0, 1'b0, 1'b1);

    // Address wrap: 0xFFFF dropped, 0x0000 written
    do_load(16'hFFFF, 16'd2, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b0);
    bus.ip = 16'h0000;
    tick();
    chk("wrap_word", bus.instruction1, mem_m[0]);

    // Asynchronous reset between halves of a load
    bus.ip  = 16'h0010;
    bus.ip2 = 16'h0011;
    bus.load_base_address = 16'(DEPTH);
    bus.load_count = 16'd2;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    err_m = 1'b0;
    send_half($urandom, ok);
    send_half($urandom, ok);
    err_m = 1'b1;
    send_half(32'hDEADBEEF, ok);
    bus.load_valid = 1'b0;
    tick();
    chk("err_before_reset", 64'(bus.load_error), 64'(err_m));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_instr1", bus.instruction1, 64'd0);
    chk("arst_instr2", bus.instruction2, 64'd0);
    chk("arst_ready", 64'(bus.load_ready), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_error", 64'(bus.load_error), 64'd0);
    err_m = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_ready", 64'(bus.load_ready), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("kept_word0", bus.instruction1, mem_m[32'h10]);
    chk("kept_word1", bus.instruction2, mem_m[32'h11]);

    // Random loads with random fetch traffic
    rand_rd = 1'b1;
    for (int i = 0; i < 25; i++) begin
      int unsigned sel;
      logic [15:0] b;
      sel = $urandom_range(0, 9);
      b = (sel == 0) ? 16'(DEPTH - 2) : (sel == 1) ? 16'hFFFE : 16'($urandom_range(0, 60));
      wa = {$urandom, $urandom};
      wb = {$urandom, $urandom};
      do_load(b, 16'($urandom_range(0, 3)), wa, wb, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_rd = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
